// File: rtl/umc_pkg.sv
// rtl/umc_pkg.sv - shared read-FSM state and read-mode constants for uart_ring_mem_ctrl
package umc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD    = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic MODE_FIFO   = 1'b0;
  localparam logic MODE_REPLAY = 1'b1;

endpackage

// File: rtl/ram_sdp.sv
// rtl/ram_sdp.sv - simple dual-port RAM, one write port, one registered ren-gated read port
module ram_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk,
  input  logic                       wen,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic                       ren,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wen) mem[waddr] <= wdata;
    if (ren) rdata <= mem[raddr];
  end

endmodule

// File: rtl/uart_ring_mem_ctrl.sv
// rtl/uart_ring_mem_ctrl.sv - UART rx byte ring buffer with FIFO/REPLAY push-to-read display
// Optional macro UMC_OVERWRITE_EN: a byte received while full overwrites the oldest entry.
module uart_ring_mem_ctrl
  import umc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        rx_data,
  input  logic                     rx_done,
  input  logic                     push_read,
  input  logic                     mode,
  output logic [DATA_W-1:0]        fnd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  logic [1:0]        sync_q;
  logic              edge_q;
  logic              rd_req;
  state_t            state, state_next;
  logic              ren;
  logic              mode_r;
  logic [ADDR_W-1:0] wptr, rptr, ridx, raddr;
  logic [DATA_W-1:0] rdata;
  logic              pop, write_ok, ovw, wen, blocked;

  assign rd_req = sync_q[1] & ~edge_q;
  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));

  always_comb begin
    state_next = state;
    ren        = 1'b0;
    case (state)
      IDLE:    if (rd_req && !empty) state_next = RD;
      RD: begin
        ren        = 1'b1;
        state_next = LATCH;
      end
      LATCH:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A pop in the same cycle frees a slot, so a write at full is still legal then.
  assign pop      = (state == RD) && (mode_r == MODE_FIFO);
  assign write_ok = rx_done && (!full || pop);
  assign blocked  = rx_done && full && !pop;
`ifdef UMC_OVERWRITE_EN
  assign ovw      = blocked;
`else
  assign ovw      = 1'b0;
`endif
  assign wen      = write_ok || ovw;
  assign raddr    = (mode_r == MODE_REPLAY) ? rptr + ridx : rptr;

  ram_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .wen   (wen),
    .waddr (wptr),
    .wdata (rx_data),
    .ren   (ren),
    .raddr (raddr),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      edge_q   <= 1'b0;
      state    <= IDLE;
      mode_r   <= MODE_FIFO;
      wptr     <= '0;
      rptr     <= '0;
      ridx     <= '0;
      count    <= '0;
      fnd_data <= '0;
      overflow <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], push_read};
      edge_q <= sync_q[1];
      state  <= state_next;

      if (wen)        wptr <= wptr + ADDR_W'(1);
      if (pop || ovw) rptr <= rptr + ADDR_W'(1);

      case ({write_ok, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase

      if (blocked) overflow <= 1'b1;

      // Mode is only honoured between reads; a change restarts replay at the oldest entry.
      if (state == IDLE) begin
        mode_r <= mode;
        if (mode != mode_r) ridx <= '0;
      end else if (state == RD && mode_r == MODE_REPLAY) begin
        if ({1'b0, ridx} + CNT_W'(1) >= count) ridx <= '0;
        else                                   ridx <= ridx + ADDR_W'(1);
      end

      if (state == LATCH) fnd_data <= rdata;
    end
  end

endmodule

// File: tb/tb_uart_ring_mem_ctrl.sv
// tb/tb_uart_ring_mem_ctrl.sv - directed scoreboard bench for uart_ring_mem_ctrl
module tb_uart_ring_mem_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       push_read = 1'b0;
  logic       mode = 1'b0;
  logic [7:0] fnd_data;
  logic [4:0] count;
  logic       empty, full, overflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] mdl_q [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_fnd = 8'h00;
  int         m_ridx = 0;

  uart_ring_mem_ctrl #(.DATA_W(8), .DEPTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .push_read (push_read),
    .mode      (mode),
    .fnd_data  (fnd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_write(input logic [7:0] d);
    if (mdl_q.size() < 16) mdl_q.push_back(d);
    else begin
`ifdef UMC_OVERWRITE_EN
      void'(mdl_q.pop_front());
      mdl_q.push_back(d);
`endif
    end
  endtask

  task automatic model_read();
    logic [7:0] e;
    if (mdl_q.size() == 0) e = last_fnd;
    else if (mode == 1'b0) e = mdl_q.pop_front();
    else begin
      e = mdl_q[m_ridx];
      m_ridx = (m_ridx + 1 >= mdl_q.size()) ? 0 : m_ridx + 1;
    end
    last_fnd = e;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mdl_q.delete();
    last_fnd = 8'h00;
    m_ridx = 0;
  endtask

  task automatic write_byte(input logic [7:0] d);
    @(posedge clk); #1 rx_data = d; rx_done = 1'b1;
    model_write(d);
    @(posedge clk); #1 rx_done = 1'b0;
  endtask

  task automatic do_push(input bit with_write, input logic [7:0] wbyte);
    logic [7:0] e;
    model_read();
    if (with_write) model_write(wbyte);
    @(posedge clk); #1 push_read = 1'b1;
    repeat (3) @(posedge clk);
    #1 if (with_write) begin rx_data = wbyte; rx_done = 1'b1; end
    @(posedge clk); #1 rx_done = 1'b0; push_read = 1'b0;
    @(posedge clk); #1;
    e = exp_q.pop_front();
    chk("fnd_data", {24'h0, fnd_data}, {24'h0, e});
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [7:0] e;
    do_reset();
    #1;
    chk("rst_fnd", {24'h0, fnd_data}, 32'h0);
    chk("rst_count", {27'h0, count}, 32'd0);
    chk("rst_empty", {31'h0, empty}, 32'd1);
    chk("rst_full", {31'h0, full}, 32'd0);
    chk("rst_overflow", {31'h0, overflow}, 32'd0);

    write_byte(8'h12); write_byte(8'h34); write_byte(8'h56);
    #1 chk("fifo_count3", {27'h0, count}, 32'd3);
    for (int i = 0; i < 3; i++) begin
      do_push(1'b0, 8'h00);
      chk("fifo_count", {27'h0, count}, 32'(mdl_q.size()));
    end
    chk("fifo_empty", {31'h0, empty}, 32'd1);

    do_push(1'b0, 8'h00);
    chk("empty_push_count", {27'h0, count}, 32'd0);

    for (int i = 0; i <= 16; i++) write_byte(8'(i));
    #1;
    chk("ovf_full", {31'h0, full}, 32'd1);
    chk("ovf_overflow", {31'h0, overflow}, 32'd1);
    chk("ovf_count", {27'h0, count}, 32'd16);
    for (int i = 0; i < 16; i++) do_push(1'b0, 8'h00);
    chk("ovf_drain_empty", {31'h0, empty}, 32'd1);

    do_reset();
    write_byte(8'hA1); write_byte(8'hB2);
    mode = 1'b1; m_ridx = 0;
    for (int i = 0; i < 5; i++) begin
      do_push(1'b0, 8'h00);
      chk("replay_count", {27'h0, count}, 32'd2);
    end

    // Reset lands while the read FSM is in LATCH.
    @(posedge clk); #1 push_read = 1'b1;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1; push_read = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    mdl_q.delete(); last_fnd = 8'h00; m_ridx = 0;
    chk("latch_rst_fnd", {24'h0, fnd_data}, 32'h0);
    chk("latch_rst_count", {27'h0, count}, 32'd0);
    chk("latch_rst_empty", {31'h0, empty}, 32'd1);
    repeat (4) @(posedge clk);
    #1 chk("latch_rst_idle_fnd", {24'h0, fnd_data}, 32'h0);

    mode = 1'b0;
    for (int i = 0; i < 16; i++) write_byte(8'h40 + 8'(i));
    #1 chk("sim_full", {31'h0, full}, 32'd1);
    do_push(1'b1, 8'h99);
    chk("sim_count", {27'h0, count}, 32'd16);
    chk("sim_overflow", {31'h0, overflow}, 32'd0);
    do_push(1'b0, 8'h00);
    for (int i = 0; i < 15; i++) do_push(1'b0, 8'h00);
    chk("sim_drain_empty", {31'h0, empty}, 32'd1);
    chk("sim_scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
